// File: rtl/fpu_dp_pkg.sv
// Shared constants and types for the double-precision multiply result stage.
// Fix-up can be built with FPU_MUL_FTZ_EN to flush denormals to zero.
package fpu_dp_pkg;

  localparam int EXP_W  = 11;
  localparam int FRAC_W = 52;
  localparam int BIAS   = 1023;

  localparam logic [63:0] POS_INF = 64'h7FF0000000000000;
  localparam int QNAN_BIT = 51;

  localparam int FLG_NAN = 3;
  localparam int FLG_INF = 2;
  localparam int FLG_OVF = 1;
  localparam int FLG_UDF = 0;

  typedef struct packed {
    logic [63:0] res;
    logic [3:0]  flg;
  } entry_t;

endpackage

// File: rtl/fpu_dp_fixup.sv
// Classifies a raw product and applies IEEE-754 special-value fix-up.
// With FPU_MUL_FTZ_EN defined, denormal results are flushed to signed zero.
module fpu_dp_fixup
  import fpu_dp_pkg::*;
(
  input  logic [63:0] result,
  input  logic        overflow,
  input  logic        underflow,
  input  logic        sign,
  output logic [63:0] fixed,
  output logic [3:0]  flags
);

  logic [EXP_W-1:0]  exp_f;
  logic [FRAC_W-1:0] frac_f;

  assign exp_f  = result[62:52];
  assign frac_f = result[51:0];

  // Overflow outranks underflow when the multiplier raises both.
  always_comb begin
    fixed = result;
    flags = '0;
    if (overflow) begin
      fixed          = POS_INF | {sign, 63'b0};
      flags[FLG_OVF] = 1'b1;
      flags[FLG_INF] = 1'b1;
    end else if (underflow) begin
      fixed          = {sign, 63'b0};
      flags[FLG_UDF] = 1'b1;
    end else if (exp_f == '1 && frac_f != '0) begin
      fixed[QNAN_BIT] = 1'b1;
      flags[FLG_NAN]  = 1'b1;
    end else if (exp_f == '1) begin
      flags[FLG_INF] = 1'b1;
`ifdef FPU_MUL_FTZ_EN
    end else if (exp_f == '0 && frac_f != '0) begin
      fixed          = {sign, 63'b0};
      flags[FLG_UDF] = 1'b1;
`endif
    end
  end

endmodule

// File: rtl/fpu_dp_mul_result_stage.sv
// Result stage: fix-up, FIFO toward writeback, sticky flags, op counter.
// Optional macro FPU_MUL_FTZ_EN enables flush-to-zero in the fix-up.
module fpu_dp_mul_result_stage
  import fpu_dp_pkg::*;
#(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic             in_overflow,
  input  logic             in_underflow,
  input  logic             in_sign,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [3:0]       out_flags,
  input  logic             flag_clr,
  output logic [3:0]       sticky_flags,
  output logic [CNT_W-1:0] op_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  entry_t         mem [DEPTH];
  logic [PW-1:0]  wr_ptr;
  logic [PW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [63:0]    fixed;
  logic [3:0]     flags;
  logic           push;
  logic           pop;
  entry_t         head;

  fpu_dp_fixup u_fixup (
    .result    (in_result),
    .overflow  (in_overflow),
    .underflow (in_underflow),
    .sign      (in_sign),
    .fixed     (fixed),
    .flags     (flags)
  );

  // Ready depends on registered count only, so a pop never frees a full slot early.
  assign in_ready  = !rst && (count < CW'(DEPTH));
  assign out_valid = !rst && (count != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  assign head       = mem[rd_ptr];
  assign out_result = out_valid ? head.res : '0;
  assign out_flags  = out_valid ? head.flg : '0;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= '{res: fixed, flg: flags};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      sticky_flags <= '0;
      op_count     <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop) begin
        rd_ptr   <= rd_ptr + PW'(1);
        op_count <= op_count + CNT_W'(1);
      end
      count <= count + CW'(push) - CW'(pop);
      if (flag_clr) begin
        sticky_flags <= push ? flags : '0;
      end else if (push) begin
        sticky_flags <= sticky_flags | flags;
      end
    end
  end

endmodule

// File: doc/fpu_dp_mul_result_stage.md
Name: fpu_dp_mul_result_stage

Overview:
Downstream stage of the combinational double-precision multiplier (fpu_dp_multiplier). It accepts the raw 64-bit product and the overflow/underflow indications, and applies IEEE-754 fix-up (±Inf, ±0, quiet-NaN canonicalisation). Results are buffered in a small FIFO with a valid/ready handshake toward writeback. It also maintains sticky exception flags and a completed-operation counter.

Parameters:
WIDTH, 64, operand/result width (fixed double precision)
DEPTH, 2, FIFO entries; power of 2, >= 2
CNT_W, 16, width of completed-operation counter

Ports:
clk  in  1  single clock, rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  product valid from multiplier
in_ready  out  1  stage can accept a product
in_result  in  64  raw multiplier result
in_overflow  in  1  multiplier overflow
in_underflow  in  1  multiplier underflow
in_sign  in  1  product sign (A[63]^B[63])
out_valid  out  1  head entry valid
out_ready  in  1  consumer accepts head
out_result  out  64  fixed-up result
out_flags  out  4  {nan, inf, overflow, underflow} for head entry
flag_clr  in  1  clear sticky flags
sticky_flags  out  4  OR of all pushed flags since reset/clear
op_count  out  CNT_W  count of output handshakes

Behaviour:
- Reset (sync, rst=1 at edge): count, pointers, sticky_flags, op_count -> 0; out_valid=0; out_result/out_flags=0. in_ready=0 while rst is high.
- Push on in_valid&&in_ready; pop on out_valid&&out_ready. in_ready = !rst && (count < DEPTH), combinational from registered count only.
- Latency: product accepted at edge N appears with out_valid=1 after edge N (next cycle) if FIFO was empty. No same-cycle pass-through.
- Full: in_ready=0; in_valid is ignored. A simultaneous pop while full does not enable a push that cycle.
- Empty: out_valid=0; out_result/out_flags hold 0. Simultaneous push+pop when count=1: count stays 1, new entry becomes head.
- Pointers wrap modulo DEPTH. FIFO order is strictly preserved.
- Fix-up, evaluated at push (priority high to low):
  - in_overflow -> {in_sign, 11'h7FF, 52'b0}; flags overflow+inf. Overflow wins if both overflow and underflow are asserted.
  - in_underflow -> {in_sign, 63'b0}; flag underflow.
  - exp==7FF, frac!=0 -> set frac bit 51 (quiet); flag nan.
  - exp==7FF, frac==0 -> pass unchanged; flag inf.
  - otherwise -> pass unchanged; flags 0.
- Output stability: while out_valid && !out_ready, out_result and out_flags are stable.
- Sticky flags: sticky |= flags at each push edge. flag_clr clears. If clr and a push with flags occur in the same cycle, sticky = new flags (push wins).
- op_count: increments on each pop; wraps from 2^CNT_W-1 to 0.
- Reset mid-operation: all buffered entries are discarded; no output handshake occurs in the reset cycle.

Optional Feature:
FPU_MUL_FTZ_EN:
- Defined: a non-overflow, non-underflow result with exp==0 and frac!=0 (denormal) is flushed to {sign, 63'b0} and the underflow flag is set.
- Undefined: denormals pass unchanged with flags 0.

Decomposition:
- Package fpu_dp_pkg holds:
  - EXP_W=11, FRAC_W=52, BIAS=1023
  - constants POS_INF=64'h7FF0000000000000, QNAN_BIT=51
  - flag index localparams FLG_NAN=3, FLG_INF=2, FLG_OVF=1, FLG_UDF=0
- One combinational sub-module, fpu_dp_fixup, performs classification and fix-up. The top level holds the FIFO, handshake, sticky flags and counter.

Test Plan:
1. Push in_result=64'h4008000000000000 (3.0), out_ready=1 -> next cycle out_result=64'h4008000000000000, flags=0, op_count=1.
2. in_overflow=1, in_sign=0, in_result=garbage -> out_result=64'h7FF0000000000000, out_flags=4'b0110, sticky=4'b0110; then flag_clr -> sticky=0.
3. in_underflow=1, in_sign=1 -> out_result=64'h8000000000000000, out_flags=4'b0001. Overflow and underflow both asserted -> overflow result.
4. in_result=64'h7FF0000000000001 -> out_result=64'h7FF8000000000001, out_flags=4'b1000. With FPU_MUL_FTZ_EN, in_result=64'h0000000000000001 -> 64'h0, flags=4'b0001.
5. out_ready=0, push 3 products back-to-back -> in_ready drops after 2 accepted. Release out_ready -> the 2 results pop in order, op_count=2, and the third is accepted once in_ready rises.
6. Assert rst with 1 entry buffered -> the following cycle out_valid=0, sticky_flags=0, op_count=0, and in_ready=1 after rst deasserts.
